// File: rtl/boxcar_avg.sv
// Power-of-two moving-average filter: running sum over a circular sample buffer.
// One clock from accepted sample to out_valid/dout; no backpressure, every in_valid sample is taken.
module boxcar_avg #(
   parameter int DATA_W   = 16,
   parameter int MAX_LOG2 = 4,
   parameter int SIGNED   = 0,
   parameter int ROUND    = 0
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic              sclr,
   input  logic [2:0]        len_sel,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] din,
   output logic              out_valid,
   output logic [DATA_W-1:0] dout,
   output logic              filling
);

   localparam int DEPTH = 1 << MAX_LOG2;
   localparam int ACC_W = DATA_W + MAX_LOG2;
   localparam int PW    = MAX_LOG2;

   typedef enum logic {FILL, RUN} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     wp_q, wp_d;
   logic [PW-1:0]     fill_cnt_q, fill_cnt_d;
   logic [2:0]        len_q, len_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              out_valid_q, out_valid_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;

   logic [2:0]        k_eff;
   logic [PW-1:0]     n_minus1;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] old_smp;
   logic [ACC_W-1:0]  din_ext, old_ext, acc_next;

   function automatic logic [DATA_W-1:0] avg(input logic [ACC_W-1:0] s, input logic [2:0] k);
      logic [ACC_W-1:0] r;
      logic [ACC_W-1:0] sh;
      r = s;
      if (ROUND != 0 && k != 3'd0)
         r = s + (ACC_W'(1) << (k - 3'd1));
      if (SIGNED != 0)
         sh = $unsigned($signed(r) >>> k);
      else
         sh = r >> k;
      return sh[DATA_W-1:0];
   endfunction

   assign k_eff    = (len_sel > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : len_sel;
   assign n_minus1 = PW'((32'd1 << len_q) - 32'd1);
   // At the maximum window the subtraction wraps to wp itself: read before overwrite.
   assign rd_ptr   = wp_q - PW'(32'd1 << len_q);
   assign old_smp  = mem_q[rd_ptr];
   assign din_ext  = {{MAX_LOG2{(SIGNED != 0) && din[DATA_W-1]}}, din};
   assign old_ext  = {{MAX_LOG2{(SIGNED != 0) && old_smp[DATA_W-1]}}, old_smp};
   assign acc_next = acc_q + din_ext - ((state_q == RUN) ? old_ext : '0);

   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      fill_cnt_d  = fill_cnt_q;
      len_d       = len_q;
      acc_d       = acc_q;
      dout_d      = dout_q;
      out_valid_d = 1'b0;
      mem_we      = 1'b0;
      if (sclr || k_eff != len_q) begin
         acc_d      = '0;
         fill_cnt_d = '0;
         len_d      = k_eff;
         state_d    = FILL;
      end else if (in_valid) begin
         mem_we = 1'b1;
         wp_d   = wp_q + PW'(1);
         acc_d  = acc_next;
         if (state_q == RUN || fill_cnt_q == n_minus1) begin
            state_d     = RUN;
            out_valid_d = 1'b1;
            dout_d      = avg(acc_next, len_q);
         end else begin
            fill_cnt_d = fill_cnt_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_q     <= FILL;
         wp_q        <= '0;
         fill_cnt_q  <= '0;
         len_q       <= '0;
         acc_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         fill_cnt_q  <= fill_cnt_d;
         len_q       <= len_d;
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[wp_q] <= din;
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign filling   = (state_q == FILL);

endmodule

// File: doc/boxcar_avg.md
Name: boxcar_avg

Overview:
- Parametrised moving-average (boxcar) filter for sample streams.
- Successor to the fixed 16-bit, fixed-tap selectable averager.
- Window length is runtime-selectable as any power of two from 1 to 2^MAX_LOG2.
- Uses a running-sum accumulator over a circular sample buffer rather than a full adder tree. Adds signed/unsigned data, optional rounding, input/output valid strobes and window-fill tracking.

Parameters:
- DATA_W, 16, sample width in bits.
- MAX_LOG2, 4, log2 of the maximum window; buffer depth is 2^MAX_LOG2.
- SIGNED, 0, 1 = two's-complement samples with arithmetic shift; 0 = unsigned.
- ROUND, 0, 1 = add 2^(k-1) before the right shift by k (round half up); 0 = truncate (floor).

Ports:
- clk  in  1  sample clock.
- aclr  in  1  asynchronous active-high reset.
- sclr  in  1  synchronous flush, active-high.
- len_sel  in  3  window select; N = 2^len_sel; values above MAX_LOG2 clamp to MAX_LOG2.
- in_valid  in  1  din is a new sample this cycle.
- din  in  DATA_W  input sample.
- out_valid  out  1  dout holds a new full-window average.
- dout  out  DATA_W  averaged sample.
- filling  out  1  high while the window is not yet full.

Behaviour:
- One clock and one reset: aclr is asynchronous and active-high.
- aclr clears buffer pointer, accumulator, fill counter, len_q, dout and out_valid to 0, and sets filling = 1 (state FILL). The buffer contents need not be cleared.
- Accumulator width is DATA_W + MAX_LOG2, with sign extension when SIGNED = 1. It cannot overflow.
- k = effective len_sel (after clamp). len_q holds the registered k.
- States:
  - FILL: accumulate only.
  - RUN: accumulate and subtract the oldest sample.
- Per cycle, in priority order:
  1. sclr = 1, or len_sel (clamped) != len_q:
     - Flush: acc <= 0, fill_cnt <= 0, len_q <= new k, state <= FILL, out_valid <= 0.
     - Any in_valid sample this cycle is discarded.
     - The write pointer is not reset.
  2. in_valid = 1 in FILL:
     - buf[wp] <= din, wp <= wp + 1 (mod 2^MAX_LOG2), acc <= acc + din.
     - If fill_cnt == N-1: state <= RUN, out_valid <= 1, dout <= avg(acc + din).
     - Otherwise: fill_cnt++, out_valid <= 0.
  3. in_valid = 1 in RUN:
     - buf[wp] <= din, wp++, acc <= acc + din - buf[wp - N].
     - out_valid <= 1, dout <= avg(new acc).
  4. in_valid = 0: out_valid <= 0. acc and dout hold.
- avg(s) = (s + (ROUND && k > 0 ? 2^(k-1) : 0)) >> k, arithmetic shift if SIGNED, then truncated to DATA_W. The result always fits in DATA_W, with no saturation needed.
- Latency: one clock from the in_valid sample to out_valid/dout.
- First out_valid occurs on the N-th accepted sample after a reset or flush.
- N = 1 (k = 0): the first sample moves FILL to RUN; dout equals din delayed one clock.
- Stale buffer entries are never subtracted: FILL subtracts nothing, and after N writes the window holds only fresh samples.
- filling = (state == FILL), registered.
- Pointer wrap is modulo buffer depth. N = 2^MAX_LOG2 reads back the entry at wp itself, before it is overwritten (read before write).
- aclr mid-operation takes effect immediately, irrespective of clk.

Test Plan:
1. len_sel=0, unsigned, din 100, 200 on consecutive cycles -> dout 100 then 200, out_valid high one clock after each sample, filling low after the first sample.
2. len_sel=2 (N=4), din 4, 8, 12, 16, 20 -> out_valid low for the first 3 samples; then dout 10, then 14.
3. len_sel=1, din 1, 2 -> dout 1 with ROUND=0, dout 2 with ROUND=1.
4. SIGNED=1, len_sel=1, din -3, -4 -> dout -4 (0xFFFC) with ROUND=0, dout -3 (0xFFFD) with ROUND=1.
5. Running at N=4, switch len_sel to 1 while in_valid=1 -> that sample is discarded, filling goes high, and the next two samples 6, 10 yield dout 8.
6. len_sel=7 (clamps to 4), 16 samples of 0xFFFF -> dout 0xFFFF on sample 16. Then assert aclr mid-stream -> dout=0, out_valid=0 and filling=1 immediately, without waiting for clk.
